myproject_mul_share_arbiter: RTL and testbench

//  Shares one 16s x 6ns -> 22-bit signed multiplier among NUM_REQ requesters.

---
 rtl/myproject_mul_share_arbiter.sv | 150 +++++++++++++++
 tb/tb_myproject_mul_share_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/myproject_mul_share_arbiter.sv
// Round-robin arbiter that time-shares one signed x unsigned multiplier among NUM_REQ lanes.
// Two-stage pipeline: operand register (S1) followed by product/result register (S2).
module myproject_mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 22
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*din0_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*din1_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [dout_WIDTH-1:0]           res_data,
  output logic [ID_W-1:0]                 res_id
);

  logic                  s1_valid_q, s1_valid_d;
  logic [din0_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [din1_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [ID_W-1:0]       s1_id_q, s1_id_d;
  logic                  res_valid_q, res_valid_d;
  logic [dout_WIDTH-1:0] res_data_q, res_data_d;
  logic [ID_W-1:0]       res_id_q, res_id_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

  logic                  s2_free, s1_adv, s1_free;
  logic                  found, xfer;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W:0]         scan_sum;
  logic [ID_W-1:0]       scan_idx;
  logic [dout_WIDTH-1:0] a_ext, b_ext, product;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    if (v == ID_W'(NUM_REQ - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return v + ID_W'(1);
    end
  endfunction

  assign s2_free = !res_valid_q || res_ready;
  assign s1_adv  = s1_valid_q && s2_free;
  assign s1_free = !s1_valid_q || s1_adv;
  assign xfer    = ap_rst_n && found && s1_free;

  // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first valid wins.
  always_comb begin
    found     = 1'b0;
    grant_idx = {ID_W{1'b0}};
    scan_sum  = {(ID_W+1){1'b0}};
    scan_idx  = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
      end else begin
        scan_sum = scan_sum;
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = scan_idx;
      end else begin
        found     = found;
        grant_idx = grant_idx;
      end
    end
  end

  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (xfer) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // b is zero-extended, so the signed multiply of the extended operands is the exact product.
  always_comb begin
    a_ext   = {{din1_WIDTH{s1_a_q[din0_WIDTH-1]}}, s1_a_q};
    b_ext   = {{din0_WIDTH{1'b0}}, s1_b_q};
    product = $signed(a_ext) * $signed(b_ext);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;

    if (xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[grant_idx*din0_WIDTH +: din0_WIDTH];
      s1_b_d     = req_b[grant_idx*din1_WIDTH +: din1_WIDTH];
      s1_id_d    = grant_idx;
      rr_ptr_d   = wrap_inc(grant_idx);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_data_d  = product;
      res_id_d    = s1_id_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= {din0_WIDTH{1'b0}};
      s1_b_q      <= {din1_WIDTH{1'b0}};
      s1_id_q     <= {ID_W{1'b0}};
      rr_ptr_q    <= {ID_W{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {dout_WIDTH{1'b0}};
      res_id_q    <= {ID_W{1'b0}};
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rr_ptr_q    <= rr_ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_myproject_mul_share_arbiter.sv
// Self-checking bench for myproject_mul_share_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_myproject_mul_share_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int BW = 6;
  localparam int DW = 22;
  localparam int IW = 2;

  logic            ap_clk = 1'b0;
  logic            ap_rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready = 1'b1;
  logic [DW-1:0]   res_data;
  logic [IW-1:0]   res_id;

  int checks = 0;
  int failures = 0;

  myproject_mul_share_arbiter #(.NUM_REQ(N), .ID_W(IW), .din0_WIDTH(AW), .din1_WIDTH(BW), .dout_WIDTH(DW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  always #5 ap_clk = ~ap_clk;

  function automatic logic [DW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    int r;
    r = int'($signed(a)) * int'(b);
    return r[DW-1:0];
  endfunction

  task automatic do_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic drain();
    @(posedge ap_clk); #1;
    req_valid = '0; res_ready = 1'b1;
    repeat (4) @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0; req_valid = '1;
    @(negedge ap_clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    @(posedge ap_clk); #1;
    req_valid = '0;
    @(negedge ap_clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_data !== 22'h000000) begin failures++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL release_res_valid got=%b exp=0", res_valid); end
  endtask

  task automatic test_single_products();
    logic [1:0]    t_id [5];
    logic [AW-1:0] t_a  [5];
    logic [BW-1:0] t_b  [5];
    logic [DW-1:0] t_e  [5];
    t_id = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    t_a  = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE, 16'h0100};
    t_b  = '{6'd63, 6'd63, 6'd0, 6'd5, 6'd33};
    t_e  = '{22'h1F7FC1, 22'h208000, 22'h000000, 22'h3FFFF6, 22'h002100};
    for (int t = 0; t < 5; t++) begin
      @(posedge ap_clk); #1;
      req_valid = 4'b0001 << t_id[t];
      req_a[t_id[t]*AW +: AW] = t_a[t];
      req_b[t_id[t]*BW +: BW] = t_b[t];
      @(negedge ap_clk);
      checks++; if (req_ready !== (4'b0001 << t_id[t])) begin failures++; $display("FAIL single_ready[%0d] got=%b exp=%b", t, req_ready, 4'b0001 << t_id[t]); end
      @(posedge ap_clk); #1;
      req_valid = '0;
      @(negedge ap_clk);
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid[%0d] got=%b exp=0", t, res_valid); end
      @(negedge ap_clk);
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d] got=%b exp=1", t, res_valid); end
      checks++; if (res_data !== t_e[t]) begin failures++; $display("FAIL single_data[%0d] got=%h exp=%h", t, res_data, t_e[t]); end
      checks++; if (res_id !== t_id[t]) begin failures++; $display("FAIL single_id[%0d] got=%0d exp=%0d", t, res_id, t_id[t]); end
    end
    drain();
  endtask

  task automatic set_fixed_operands();
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = 16'(1000 * (i + 1) - 2500);
      req_b[i*BW +: BW] = 6'(7 * i + 3);
    end
  endtask

  task automatic test_all_valid();
    do_reset();
    set_fixed_operands();
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      @(negedge ap_clk);
      checks++; if (req_ready !== (4'b0001 << (k % N))) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, 4'b0001 << (k % N)); end
      if (k >= 2) begin
        checks++; if (res_valid !== 1'b1 || res_id !== 2'((k - 2) % N)) begin failures++; $display("FAIL rr_result[%0d] got=v%b id%0d exp=v1 id%0d", k, res_valid, res_id, (k - 2) % N); end
        checks++; if (res_data !== ref_mul(req_a[((k-2)%N)*AW +: AW], req_b[((k-2)%N)*BW +: BW])) begin failures++; $display("FAIL rr_data[%0d] got=%h", k, res_data); end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    int grants;
    logic [DW-1:0] held;
    bit have;
    do_reset();
    set_fixed_operands();
    req_valid = '1; res_ready = 1'b0;
    grants = 0; have = 0; held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      grants += $countones(req_valid & req_ready);
      if (res_valid) begin
        if (have) begin
          checks++; if (res_data !== held) begin failures++; $display("FAIL stall_hold[%0d] got=%h exp=%h", c, res_data, held); end
        end
        held = res_data; have = 1;
      end
    end
    checks++; if (grants != 2) begin failures++; $display("FAIL stall_grants got=%0d exp=2", grants); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL stall_ready got=%b exp=0000", req_ready); end
    @(posedge ap_clk); #1;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge ap_clk);
      checks++; if (res_valid !== 1'b1 || res_id !== 2'(c % N)) begin failures++; $display("FAIL resume_id[%0d] got=v%b id%0d exp=v1 id%0d", c, res_valid, res_id, c % N); end
      checks++; if (res_data !== ref_mul(req_a[(c%N)*AW +: AW], req_b[(c%N)*BW +: BW])) begin failures++; $display("FAIL resume_data[%0d] got=%h", c, res_data); end
    end
    drain();
  endtask

  task automatic test_reset_full();
    do_reset();
    set_fixed_operands();
    req_valid = '1; res_ready = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0; res_ready = 1'b1;
    @(negedge ap_clk);
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rstfull_ready_in_reset got=%b exp=0000", req_ready); end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rstfull_valid got=%b exp=0", res_valid); end
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstfull_ptr got=%b exp=0001", req_ready); end
    @(negedge ap_clk);
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rstfull_no_early got=%b exp=0", res_valid); end
    @(negedge ap_clk);
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd0) begin failures++; $display("FAIL rstfull_first got=v%b id%0d exp=v1 id0", res_valid, res_id); end
    drain();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_data_q[$];
    logic [IW-1:0] exp_id_q[$];
    logic [N-1:0]  exp_rdy, dut_xfer;
    logic [DW-1:0] ed;
    logic [IW-1:0] ei;
    int rr, idx, gi;
    bit free, fnd;
    do_reset();
    rr = 0;
    for (int cyc = 0; cyc < 10006; cyc++) begin
      @(negedge ap_clk);
      free = !(exp_data_q.size() == 2 && !res_ready);
      exp_rdy = '0; fnd = 0; gi = 0;
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (!fnd && req_valid[idx]) begin
          fnd = 1; gi = idx;
          if (free) exp_rdy[idx] = 1'b1;
        end
      end
      checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); end
      if (res_valid && res_ready) begin
        if (exp_data_q.size() == 0) begin
          checks++; failures++; $display("FAIL rand_spurious cyc=%0d got=id%0d data=%h exp=none", cyc, res_id, res_data);
        end else begin
          ed = exp_data_q.pop_front(); ei = exp_id_q.pop_front();
          checks++; if (res_data !== ed || res_id !== ei) begin failures++; $display("FAIL rand_result cyc=%0d got=id%0d %h exp=id%0d %h", cyc, res_id, res_data, ei, ed); end
        end
      end
      if (fnd && free) begin
        exp_data_q.push_back(ref_mul(req_a[gi*AW +: AW], req_b[gi*BW +: BW]));
        exp_id_q.push_back(IW'(gi));
        rr = (gi + 1) % N;
      end
      dut_xfer = req_valid & req_ready;
      @(posedge ap_clk); #1;
      if (cyc >= 10000) begin
        req_valid = '0; res_ready = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && !dut_xfer[i]) begin
            if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
          end else begin
            req_valid[i] = 1'($urandom_range(1));
            req_a[i*AW +: AW] = 16'($urandom);
            req_b[i*BW +: BW] = 6'($urandom);
          end
        end
        res_ready = ($urandom_range(3) != 0);
      end
    end
    checks++; if (exp_data_q.size() != 0) begin failures++; $display("FAIL rand_lost got=%0d outstanding exp=0", exp_data_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_products();
    test_all_valid();
    test_backpressure();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
